snake_list_render: RTL and testbench

Parametrised successor to the fixed 16×16 snake map reader. It walks the circular snake-segment list held in the Gowin_DPB through channel B and rasterises it into a GRID_W×GRID_H occupancy bitmap. The bitmap is double-buffered, so the HDMI side only ever sees complete frames. The block also detects head/body collision and out-of-grid segments. It sits between the channel-A list writer (which supplies head address and length, and pulses `start` when it finishes writing) and the HDMI map consumer.

---
 rtl/snake_pkg.sv | 44 ++++
 rtl/snake_dpb_rd_pipe.sv | 59 +++++
 rtl/snake_list_render.sv | 171 +++++++++++++++++
 tb/tb_snake_list_render.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared types and helpers for the snake list renderer.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
//
// Holds the forward-direction codes used by the list writer, the render FSM
// state enum, and pack/unpack helpers for positions encoded as {y, x}.
package snake_pkg;

  typedef enum logic [1:0] {
    X_UP   = 2'd0,
    X_DOWN = 2'd1,
    Y_UP   = 2'd2,
    Y_DOWN = 2'd3
  } dir_t;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    ISSUE,
    DRAIN,
    PUBLISH
  } state_t;

  // Widest position supported: 64x64 grid -> 6 + 6 bits.
  localparam int POS_MAX_W = 12;

  // x field: low xw bits of the position word.
  function automatic logic [5:0] pos_x(input logic [POS_MAX_W-1:0] pos, input int xw);
    logic [POS_MAX_W-1:0] mask;
    mask = (POS_MAX_W'(1) << xw) - POS_MAX_W'(1);
    return 6'(pos & mask);
  endfunction

  // y field: everything above the x field.
  function automatic logic [5:0] pos_y(input logic [POS_MAX_W-1:0] pos, input int xw);
    return 6'(pos >> xw);
  endfunction

  function automatic logic [POS_MAX_W-1:0] pos_pack(input logic [5:0] x, input logic [5:0] y,
                                                    input int xw);
    return (POS_MAX_W'(y) << xw) | POS_MAX_W'(x);
  endfunction

endpackage

// File: rtl/snake_dpb_rd_pipe.sv
// DPB channel-B read issue plus RD_LAT-deep valid/index tag pipeline.
// Latency: a word addressed in cycle n is presented as rd_vld/rd_dat in cycle n+RD_LAT.
// Backpressure: none; the RAM returns one word per issued address.
//
// Ports: issue/head_addr/issue_idx select the address (head_addr - issue_idx);
// b_ce/b_oce/b_addr drive the RAM; b_dout returns data; rd_vld/rd_idx/rd_dat
// tag each returned word; pipe_empty is high when no read is outstanding.
module snake_dpb_rd_pipe #(
  parameter int ADDR_W = 11,
  parameter int POS_W  = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue,
  input  logic [ADDR_W-1:0] head_addr,
  input  logic [ADDR_W-1:0] issue_idx,
  output logic              b_ce,
  output logic              b_oce,
  output logic [ADDR_W-1:0] b_addr,
  input  logic [POS_W-1:0]  b_dout,
  output logic              rd_vld,
  output logic [ADDR_W-1:0] rd_idx,
  output logic [POS_W-1:0]  rd_dat,
  output logic              pipe_empty
);

  logic [RD_LAT-1:0] vld_sr;
  logic [ADDR_W-1:0] idx_sr [RD_LAT];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_sr <= '0;
      for (int i = 0; i < RD_LAT; i++) idx_sr[i] <= '0;
    end else begin
      vld_sr[0] <= issue;
      idx_sr[0] <= issue_idx;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_sr[i] <= vld_sr[i-1];
        idx_sr[i] <= idx_sr[i-1];
      end
    end
  end

  assign pipe_empty = ~|vld_sr;

  // Enables stay up while reads are still in flight so that, with the
  // output register in use (RD_LAT=2), the last word is clocked out too.
  assign b_ce  = issue | ~pipe_empty;
  assign b_oce = issue | ~pipe_empty;

  // Walking backwards from the head; modular subtraction gives the wrap.
  assign b_addr = issue ? (head_addr - issue_idx) : '0;

  assign rd_vld = vld_sr[RD_LAT-1];
  assign rd_idx = idx_sr[RD_LAT-1];
  assign rd_dat = b_dout;

endmodule

// File: rtl/snake_list_render.sv
// Renders the circular snake list from DPB channel B into a double-buffered bitmap.
// Latency: map_valid L+RD_LAT+3 edges after start (2 edges for L=0).
// Backpressure: none; start is dropped while busy, one list entry read per cycle.
//
// Ports: start/list_head_addr/list_length request a render; b_* is the DPB
// channel-B read port; busy marks a render in progress; map_flat/head_pos/
// game_over are the published frame, refreshed with the map_valid pulse.
// Optional feature macro: SNAKE_RENDER_COLLIDE_EN (collision and range flag).
module snake_list_render
  import snake_pkg::*;
#(
  parameter int GRID_W  = 16,
  parameter int GRID_H  = 16,
  parameter int ADDR_W  = 11,
  parameter int RD_LAT  = 1,
  localparam int XW     = $clog2(GRID_W),
  localparam int YW     = $clog2(GRID_H),
  localparam int POS_W  = XW + YW
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ADDR_W-1:0]        list_head_addr,
  input  logic [ADDR_W-1:0]        list_length,
  output logic                     b_ce,
  output logic                     b_oce,
  output logic                     b_we,
  output logic [ADDR_W-1:0]        b_addr,
  output logic [POS_W-1:0]         b_din,
  input  logic [POS_W-1:0]         b_dout,
  output logic                     busy,
  output logic [GRID_W*GRID_H-1:0] map_flat,
  output logic                     map_valid,
  output logic [POS_W-1:0]         head_pos,
  output logic                     game_over
);

  localparam int MAP_N = GRID_W * GRID_H;
  localparam int MI_W  = $clog2(MAP_N);

  state_t state, state_nxt;

  logic [ADDR_W-1:0] head_q, len_q, idx_q;
  logic [MAP_N-1:0]  work_map;
  logic [POS_W-1:0]  work_head;

  logic              issue;
  logic              rd_vld;
  logic [ADDR_W-1:0] rd_idx;
  logic [POS_W-1:0]  rd_dat;
  logic              pipe_empty;

  logic [XW-1:0]     seg_x;
  logic [YW-1:0]     seg_y;
  logic              seg_in;
  logic [MI_W-1:0]   seg_bit;

  assign issue = (state == ISSUE);
  assign busy  = (state != IDLE);
  assign b_we  = 1'b0;
  assign b_din = '0;

  snake_dpb_rd_pipe #(
    .ADDR_W (ADDR_W),
    .POS_W  (POS_W),
    .RD_LAT (RD_LAT)
  ) u_rd_pipe (
    .clk        (clk),
    .rst        (rst),
    .issue      (issue),
    .head_addr  (head_q),
    .issue_idx  (idx_q),
    .b_ce       (b_ce),
    .b_oce      (b_oce),
    .b_addr     (b_addr),
    .b_dout     (b_dout),
    .rd_vld     (rd_vld),
    .rd_idx     (rd_idx),
    .rd_dat     (rd_dat),
    .pipe_empty (pipe_empty)
  );

  // Decode the returned segment. With non power-of-two grids the x/y fields
  // can hold values past the edge; those are never drawn.
  assign seg_x   = XW'(pos_x(POS_MAX_W'(rd_dat), XW));
  assign seg_y   = YW'(pos_y(POS_MAX_W'(rd_dat), XW));
  assign seg_in  = ({1'b0, seg_x} < (XW+1)'(GRID_W)) && ({1'b0, seg_y} < (YW+1)'(GRID_H));
  assign seg_bit = MI_W'(int'(seg_y) * GRID_W + int'(seg_x));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CLEAR;
      CLEAR:   state_nxt = (len_q == '0) ? PUBLISH : ISSUE;
      ISSUE:   if (idx_q == len_q - ADDR_W'(1)) state_nxt = DRAIN;
      DRAIN:   if (pipe_empty) state_nxt = PUBLISH;
      PUBLISH: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

`ifdef SNAKE_RENDER_COLLIDE_EN
  logic work_flag;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q    <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      work_map  <= '0;
      work_head <= '0;
      map_flat  <= '0;
      head_pos  <= '0;
      map_valid <= 1'b0;
`ifdef SNAKE_RENDER_COLLIDE_EN
      work_flag <= 1'b0;
      game_over <= 1'b0;
`endif
    end else begin
      map_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            head_q <= list_head_addr;
            len_q  <= list_length;
          end
        end
        CLEAR: begin
          work_map  <= '0;
          work_head <= '0;
          idx_q     <= '0;
`ifdef SNAKE_RENDER_COLLIDE_EN
          work_flag <= 1'b0;
`endif
        end
        ISSUE: idx_q <= idx_q + ADDR_W'(1);
        PUBLISH: begin
          map_flat  <= work_map;
          head_pos  <= work_head;
          map_valid <= 1'b1;
`ifdef SNAKE_RENDER_COLLIDE_EN
          game_over <= work_flag;
`endif
        end
        default: ;
      endcase

      // Returned words never overlap CLEAR: the previous render has drained.
      if (rd_vld) begin
        if (rd_idx == '0) work_head <= rd_dat;
        if (seg_in) work_map[seg_bit] <= 1'b1;
`ifdef SNAKE_RENDER_COLLIDE_EN
        if (!seg_in) work_flag <= 1'b1;
        // work_head was captured on the previous word, so body words see it.
        if ((rd_idx != '0) && (rd_dat == work_head)) work_flag <= 1'b1;
`endif
      end
    end
  end

`ifndef SNAKE_RENDER_COLLIDE_EN
  assign game_over = 1'b0;
`endif

endmodule

// File: tb/tb_snake_list_render.sv
// Bench: two renderers (16x16/RD_LAT=1 and 12x12/RD_LAT=2) sharing one list RAM image.
module tb_snake_list_render;

  localparam int AW = 11;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic [AW-1:0] list_head_addr = '0;
  logic [AW-1:0] list_length = '0;

  logic          b_ce_a, b_oce_a, b_we_a, busy_a, map_valid_a, game_over_a;
  logic [AW-1:0] b_addr_a;
  logic [7:0]    b_din_a, b_dout_a, head_pos_a;
  logic [255:0]  map_flat_a;

  logic          b_ce_b, b_oce_b, b_we_b, busy_b, map_valid_b, game_over_b;
  logic [AW-1:0] b_addr_b;
  logic [7:0]    b_din_b, b_dout_b, head_pos_b, s1_b;
  logic [143:0]  map_flat_b;

  logic [7:0]    mem [2048];
  logic [AW-1:0] addr_a [$];

  int vectors = 0;
  int miscompares = 0;

  int           lat_a, lat_b, pulses_a, pulses_b, unstable;
  logic [255:0] om_a, om_b, pm_a, pm_b, em_a, em_b;
  logic [7:0]   oh_a, oh_b, eh_a, eh_b;
  logic         og_a, og_b, eg_a, eg_b;

  always #5 clk = ~clk;

  snake_list_render #(.GRID_W(16), .GRID_H(16), .ADDR_W(AW), .RD_LAT(1)) dut_a (
    .clk(clk), .rst(rst), .start(start), .list_head_addr(list_head_addr),
    .list_length(list_length), .b_ce(b_ce_a), .b_oce(b_oce_a), .b_we(b_we_a),
    .b_addr(b_addr_a), .b_din(b_din_a), .b_dout(b_dout_a), .busy(busy_a),
    .map_flat(map_flat_a), .map_valid(map_valid_a), .head_pos(head_pos_a),
    .game_over(game_over_a)
  );

  snake_list_render #(.GRID_W(12), .GRID_H(12), .ADDR_W(AW), .RD_LAT(2)) dut_b (
    .clk(clk), .rst(rst), .start(start), .list_head_addr(list_head_addr),
    .list_length(list_length), .b_ce(b_ce_b), .b_oce(b_oce_b), .b_we(b_we_b),
    .b_addr(b_addr_b), .b_din(b_din_b), .b_dout(b_dout_b), .busy(busy_b),
    .map_flat(map_flat_b), .map_valid(map_valid_b), .head_pos(head_pos_b),
    .game_over(game_over_b)
  );

  // RAM A: single output stage. RAM B: address stage plus output register.
  always @(posedge clk) begin
    if (b_ce_a && b_oce_a) b_dout_a <= mem[b_addr_a];
    if (b_ce_b) s1_b <= mem[b_addr_b];
    if (b_oce_b) b_dout_b <= s1_b;
    if (b_ce_a) addr_a.push_back(b_addr_a);
  end

  // Reference: walk the list backwards from the head and draw each segment.
  task automatic model(input logic [AW-1:0] head, input int len, input int w, input int h,
                       output logic [255:0] m, output logic [7:0] hp, output logic go);
    m = '0; hp = '0; go = 1'b0;
    for (int i = 0; i < len; i++) begin
      logic [AW-1:0] a;
      logic [7:0] p;
      int x, y;
      a = head - AW'(i);
      p = mem[a];
      x = int'(p[3:0]);
      y = int'(p[7:4]);
      if (i == 0) hp = p;
      if (x < w && y < h) m[y*w + x] = 1'b1;
      else go = 1'b1;
      if (i > 0 && p == hp) go = 1'b1;
    end
`ifndef SNAKE_RENDER_COLLIDE_EN
    go = 1'b0;
`endif
  endtask

  // Issue one render, optionally with a second start while busy, and record
  // what both DUTs publish plus the expected frame from the model.
  task automatic run(input logic [AW-1:0] head, input int len, input int second_at);
    @(negedge clk);
    list_head_addr = head;
    list_length = AW'(len);
    start = 1'b1;
    addr_a.delete();
    @(posedge clk); #1;
    start = 1'b0;
    lat_a = -1; lat_b = -1; pulses_a = 0; pulses_b = 0; unstable = 0;
    for (int e = 1; e <= len + 12; e++) begin
      @(posedge clk); #1;
      if (!map_valid_a && lat_a < 0 && map_flat_a !== pm_a) unstable++;
      if (!map_valid_b && lat_b < 0 && 256'(map_flat_b) !== pm_b) unstable++;
      if (map_valid_a) begin
        pulses_a++;
        if (lat_a < 0) begin lat_a = e; om_a = map_flat_a; oh_a = head_pos_a; og_a = game_over_a; end
      end
      if (map_valid_b) begin
        pulses_b++;
        if (lat_b < 0) begin lat_b = e; om_b = 256'(map_flat_b); oh_b = head_pos_b; og_b = game_over_b; end
      end
      start = (e == second_at);
    end
    start = 1'b0;
    pm_a = map_flat_a;
    pm_b = 256'(map_flat_b);
    model(head, len, 16, 16, em_a, eh_a, eg_a);
    model(head, len, 12, 12, em_b, eh_b, eg_b);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #12;
    vectors++; if ({busy_a, map_valid_a, game_over_a, b_ce_a, b_oce_a, b_we_a} !== 6'b0) begin
      miscompares++; $display("FAIL reset_ctl_a: got %b want 000000", {busy_a, map_valid_a, game_over_a, b_ce_a, b_oce_a, b_we_a}); end
    vectors++; if ({busy_b, map_valid_b, game_over_b, b_ce_b, b_oce_b, b_we_b} !== 6'b0) begin
      miscompares++; $display("FAIL reset_ctl_b: got %b want 000000", {busy_b, map_valid_b, game_over_b, b_ce_b, b_oce_b, b_we_b}); end
    vectors++; if ({map_flat_a, head_pos_a, b_addr_a, b_din_a} !== '0) begin
      miscompares++; $display("FAIL reset_data_a: got nonzero want 0"); end
    vectors++; if ({map_flat_b, head_pos_b, b_addr_b, b_din_b} !== '0) begin
      miscompares++; $display("FAIL reset_data_b: got nonzero want 0"); end
    @(negedge clk);
    rst = 1'b1;
    pm_a = '0; pm_b = '0;
  endtask

  task automatic test_basic();
    mem[5] = 8'h23; mem[4] = 8'h24; mem[3] = 8'h25;
    run(11'd5, 3, 0);
    vectors++; if (lat_a !== 7) begin miscompares++; $display("FAIL basic_lat_a: got %0d want 7", lat_a); end
    vectors++; if (lat_b !== 8) begin miscompares++; $display("FAIL basic_lat_b: got %0d want 8", lat_b); end
    vectors++; if (om_a !== (256'h7 << 35)) begin miscompares++; $display("FAIL basic_map_a: got %h want %h", om_a, 256'h7 << 35); end
    vectors++; if (om_b !== em_b) begin miscompares++; $display("FAIL basic_map_b: got %h want %h", om_b, em_b); end
    vectors++; if (oh_a !== 8'h23) begin miscompares++; $display("FAIL basic_head_a: got %h want 23", oh_a); end
    vectors++; if (oh_b !== 8'h23) begin miscompares++; $display("FAIL basic_head_b: got %h want 23", oh_b); end
    vectors++; if (og_a !== 1'b0) begin miscompares++; $display("FAIL basic_go_a: got %b want 0", og_a); end
  endtask

  task automatic test_wrap();
    logic [AW-1:0] want [4];
    want = '{11'd1, 11'd0, 11'd2047, 11'd2046};
    mem[1] = 8'h11; mem[0] = 8'h22; mem[2047] = 8'h33; mem[2046] = 8'hB4;
    run(11'd1, 4, 0);
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (addr_a.size() <= k || addr_a[k] !== want[k]) begin
        miscompares++;
        $display("FAIL wrap_addr%0d: got %0d want %0d", k, (addr_a.size() > k) ? addr_a[k] : 11'd0, want[k]);
      end
    end
    vectors++; if (om_a !== em_a) begin miscompares++; $display("FAIL wrap_map_a: got %h want %h", om_a, em_a); end
    vectors++; if (om_b !== em_b) begin miscompares++; $display("FAIL wrap_map_b: got %h want %h", om_b, em_b); end
  endtask

  task automatic test_collision();
    mem[10] = 8'h44; mem[9] = 8'h45; mem[8] = 8'h44;
    run(11'd10, 3, 0);
    vectors++; if (og_a !== eg_a) begin miscompares++; $display("FAIL collide_go_a: got %b want %b", og_a, eg_a); end
    vectors++; if (og_b !== eg_b) begin miscompares++; $display("FAIL collide_go_b: got %b want %b", og_b, eg_b); end
    vectors++; if (om_a !== em_a) begin miscompares++; $display("FAIL collide_map_a: got %h want %h", om_a, em_a); end
  endtask

  task automatic test_out_of_range();
    mem[20] = 8'h0E;
    run(11'd20, 1, 0);
    vectors++; if (om_b !== '0) begin miscompares++; $display("FAIL oor_map_b: got %h want 0", om_b); end
    vectors++; if (og_b !== eg_b) begin miscompares++; $display("FAIL oor_go_b: got %b want %b", og_b, eg_b); end
    vectors++; if (om_a !== (256'h1 << 14)) begin miscompares++; $display("FAIL oor_map_a: got %h want %h", om_a, 256'h1 << 14); end
    vectors++; if (og_a !== 1'b0) begin miscompares++; $display("FAIL oor_go_a: got %b want 0", og_a); end
  endtask

  task automatic test_empty();
    run(11'd77, 0, 0);
    vectors++; if (lat_a !== 2) begin miscompares++; $display("FAIL empty_lat_a: got %0d want 2", lat_a); end
    vectors++; if (lat_b !== 2) begin miscompares++; $display("FAIL empty_lat_b: got %0d want 2", lat_b); end
    vectors++; if ({om_a, oh_a, og_a} !== '0) begin miscompares++; $display("FAIL empty_out_a: got %h/%h/%b want 0", om_a, oh_a, og_a); end
    vectors++; if ({om_b, oh_b, og_b} !== '0) begin miscompares++; $display("FAIL empty_out_b: got %h/%h/%b want 0", om_b, oh_b, og_b); end
  endtask

  task automatic test_busy_start();
    for (int i = 0; i < 6; i++) mem[30 - i] = 8'(8'h50 + i);
    run(11'd30, 6, 2);
    vectors++; if (pulses_a !== 1) begin miscompares++; $display("FAIL busy_pulses_a: got %0d want 1", pulses_a); end
    vectors++; if (pulses_b !== 1) begin miscompares++; $display("FAIL busy_pulses_b: got %0d want 1", pulses_b); end
    vectors++; if (om_a !== em_a) begin miscompares++; $display("FAIL busy_map_a: got %h want %h", om_a, em_a); end
    vectors++; if (lat_b !== 11) begin miscompares++; $display("FAIL busy_lat_b: got %0d want 11", lat_b); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 10; i++) mem[40 - i] = 8'($urandom_range(0, 255));
    @(negedge clk);
    list_head_addr = 11'd40; list_length = 11'd10; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int e = 1; e <= 4; e++) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    vectors++; if ({busy_a, map_valid_a, game_over_a, b_ce_a, b_addr_a, head_pos_a, map_flat_a} !== '0) begin
      miscompares++; $display("FAIL abort_a: got busy=%b ce=%b head=%h want all 0", busy_a, b_ce_a, head_pos_a); end
    vectors++; if ({busy_b, map_valid_b, game_over_b, b_ce_b, b_addr_b, head_pos_b, map_flat_b} !== '0) begin
      miscompares++; $display("FAIL abort_b: got busy=%b ce=%b head=%h want all 0", busy_b, b_ce_b, head_pos_b); end
    @(negedge clk);
    rst = 1'b1;
    pm_a = '0; pm_b = '0;
    run(11'd40, 10, 0);
    vectors++; if (lat_a !== 14) begin miscompares++; $display("FAIL rerun_lat_a: got %0d want 14", lat_a); end
    vectors++; if (om_a !== em_a) begin miscompares++; $display("FAIL rerun_map_a: got %h want %h", om_a, em_a); end
    vectors++; if (om_b !== em_b) begin miscompares++; $display("FAIL rerun_map_b: got %h want %h", om_b, em_b); end
    vectors++; if (oh_b !== eh_b) begin miscompares++; $display("FAIL rerun_head_b: got %h want %h", oh_b, eh_b); end
  endtask

  task automatic test_sweep();
    for (int len = 1; len <= 20; len++) begin
      logic [AW-1:0] head;
      head = AW'($urandom_range(0, 2047));
      for (int i = 0; i < len; i++) begin
        logic [AW-1:0] a;
        a = head - AW'(i);
        mem[a] = 8'($urandom_range(0, 255));
        if (i > 0 && $urandom_range(0, 7) == 0) mem[a] = mem[head];
      end
      run(head, len, 0);
      vectors++; if (lat_a !== len + 4) begin miscompares++; $display("FAIL sweep%0d_lat_a: got %0d want %0d", len, lat_a, len + 4); end
      vectors++; if (lat_b !== len + 5) begin miscompares++; $display("FAIL sweep%0d_lat_b: got %0d want %0d", len, lat_b, len + 5); end
      vectors++; if (om_a !== em_a) begin miscompares++; $display("FAIL sweep%0d_map_a: got %h want %h", len, om_a, em_a); end
      vectors++; if (om_b !== em_b) begin miscompares++; $display("FAIL sweep%0d_map_b: got %h want %h", len, om_b, em_b); end
      vectors++; if (oh_a !== eh_a) begin miscompares++; $display("FAIL sweep%0d_head_a: got %h want %h", len, oh_a, eh_a); end
      vectors++; if (oh_b !== eh_b) begin miscompares++; $display("FAIL sweep%0d_head_b: got %h want %h", len, oh_b, eh_b); end
      vectors++; if (og_a !== eg_a) begin miscompares++; $display("FAIL sweep%0d_go_a: got %b want %b", len, og_a, eg_a); end
      vectors++; if (og_b !== eg_b) begin miscompares++; $display("FAIL sweep%0d_go_b: got %b want %b", len, og_b, eg_b); end
      vectors++; if (pulses_a + pulses_b !== 2) begin miscompares++; $display("FAIL sweep%0d_pulses: got %0d want 2", len, pulses_a + pulses_b); end
      vectors++; if (unstable !== 0) begin miscompares++; $display("FAIL sweep%0d_stable: got %0d changes want 0", len, unstable); end
    end
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
    b_dout_a = '0; b_dout_b = '0; s1_b = '0;
    test_reset();
    test_basic();
    test_wrap();
    test_collision();
    test_out_of_range();
    test_empty();
    test_busy_start();
    test_reset_mid();
    test_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
